// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory: size encodings, FSM states,
// and helpers for byte-enable generation and load extension.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        IDLE,
        SPLIT
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'd1;
            SZ_HALF: return 4'd2;
            SZ_WORD: return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Right-aligned byte-enable mask for an access of the given size.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            SZ_WORD: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] data,
                                                input logic [1:0]  size,
                                                input logic        is_unsigned);
        case (size)
            SZ_BYTE: return is_unsigned ? {56'd0, data[7:0]}  : {{56{data[7]}}, data[7:0]};
            SZ_HALF: return is_unsigned ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
            SZ_WORD: return is_unsigned ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// One byte lane of the data memory: DEPTH x 8 synchronous-read RAM with a
// single write enable.
module dmem_lane_ram #(
    parameter int    DEPTH     = 2048,
    parameter int    AW        = $clog2(DEPTH),
    parameter string INIT_FILE = "",
    parameter int    LANE      = 0
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    // NOTE: neither the array nor the read register is reset; a reset here would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_banked.sv
// Banked byte-lane data memory with valid/ready requests and 1-cycle responses.
// Define DMEM_MISALIGN_SPLIT_EN to service misaligned accesses as two word accesses.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int    LANES     = 4,
    parameter int    DEPTH     = 2048,
    parameter int    ADDR_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [8*LANES-1:0]   req_wdata,
    output logic                 rsp_valid,
    output logic [8*LANES-1:0]   rsp_rdata,
    output logic                 rsp_err
);

    localparam int DW  = 8 * LANES;
    localparam int BW2 = 2 * LANES;
    localparam int LW  = $clog2(LANES);
    localparam int AW  = $clog2(DEPTH);
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic [LW-1:0]     req_off;
    logic [ADDR_W-1:0] req_widx;
    logic              size_bad, range_bad, misaligned, req_err, accept;
    logic [BW2-1:0]    wide_be;
    logic [2*DW-1:0]   wide_wd;

    logic [AW-1:0]     ram_addr;
    logic [LANES-1:0]  ram_be;
    logic [DW-1:0]     ram_wd, ram_rd;

    state_e            state_q, state_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic              rsp_load_q, rsp_load_d, uns_q, uns_d, split_q, split_d;
    logic [1:0]        size_q, size_d;
    logic [LW-1:0]     off_q, off_d;
    logic [DW-1:0]     lo_q, lo_d, hi_wd_q, hi_wd_d;
    logic [AW-1:0]     widx_q, widx_d;
    logic              hi_we_q, hi_we_d;
    logic [LANES-1:0]  hi_be_q, hi_be_d;

    logic [DW-1:0]     lo_word, rot_word;

    assign req_off    = req_addr[LW-1:0];
    assign req_widx   = req_addr >> LW;
    assign size_bad   = (req_size == 2'd3) || (int'(size_bytes(req_size)) > LANES);
    assign range_bad  = req_widx >= ADDR_W'(DEPTH);
    assign misaligned = (4'(req_off) & (size_bytes(req_size) - 4'd1)) != 4'd0;
    assign req_err    = size_bad || range_bad || (misaligned && !SPLIT_EN);
    assign req_ready  = !rst && (state_q == IDLE);
    assign accept     = req_valid && req_ready;

    // Enables and data spread over two words; the upper half only matters for split accesses.
    assign wide_be = BW2'(LANES'(size_mask(req_size))) << req_off;
    assign wide_wd = {{DW{1'b0}}, req_wdata} << {req_off, 3'b000};

    always_comb begin
        // NOTE: every signal written here gets a default first so no latches are inferred.
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_load_d  = rsp_load_q;
        size_d      = size_q;
        off_d       = off_q;
        uns_d       = uns_q;
        split_d     = split_q;
        lo_d        = lo_q;
        widx_d      = widx_q;
        hi_we_d     = hi_we_q;
        hi_be_d     = hi_be_q;
        hi_wd_d     = hi_wd_q;
        ram_addr    = req_widx[AW-1:0];
        ram_be      = '0;
        ram_wd      = wide_wd[DW-1:0];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_load_d = !req_we && !req_err;
                    size_d     = req_size;
                    off_d      = req_off;
                    uns_d      = req_unsigned;
                    split_d    = !req_err && misaligned;
                    if (!req_err && req_we) begin
                        ram_be = wide_be[LANES-1:0];
                    end
                    if (!req_err && misaligned) begin
                        state_d = SPLIT;
                        widx_d  = req_widx[AW-1:0];
                        hi_we_d = req_we;
                        hi_be_d = wide_be[BW2-1:LANES];
                        hi_wd_d = wide_wd[2*DW-1:DW];
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = req_err;
                    end
                end
            end
            SPLIT: begin
                // Second access wraps modulo DEPTH through the AW-bit add.
                ram_addr    = widx_q + AW'(1);
                ram_be      = hi_we_q ? hi_be_q : '0;
                ram_wd      = hi_wd_q;
                lo_d        = ram_rd;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= '0;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            lo_q        <= '0;
            widx_q      <= '0;
            hi_we_q     <= 1'b0;
            hi_be_q     <= '0;
            hi_wd_q     <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= uns_d;
            split_q     <= split_d;
            lo_q        <= lo_d;
            widx_q      <= widx_d;
            hi_we_q     <= hi_we_d;
            hi_be_q     <= hi_be_d;
            hi_wd_q     <= hi_wd_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dmem_lane_ram #(
            .DEPTH     (DEPTH),
            .AW        (AW),
            .INIT_FILE (INIT_FILE),
            .LANE      (i)
        ) u_ram (
            .clk   (clk),
            .we    (ram_be[i]),
            .addr  (ram_addr),
            .wdata (ram_wd[8*i +: 8]),
            .rdata (ram_rd[8*i +: 8])
        );
    end

    // A plain access rotates one word; a split access merges the captured low word with the new one.
    assign lo_word   = split_q ? lo_q : ram_rd;
    assign rot_word  = DW'({ram_rd, lo_word} >> {off_q, 3'b000});
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && rsp_load_q) ? DW'(load_extend(64'(rot_word), size_q, uns_q)) : '0;

endmodule

// File: tb/tb_dmem_banked.sv
// Randomised scoreboard bench for dmem_banked against a flat byte-array memory model.
`timescale 1ns/1ps
module tb_dmem_banked;
    import dmem_pkg::*;

    localparam int LANES  = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    dmem_banked #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_m [4*DEPTH];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Flat byte-addressed model: an access touches bytes addr..addr+bytes-1 modulo the memory size.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata, output int lat);
        int          bytes;
        logic        misal;
        logic [31:0] val;
        bytes = 1 << size;
        misal = (addr % bytes) != 0;
        err   = (size == 2'd3) || ((addr / 4) >= DEPTH) || (misal && !SPLIT_EN);
        rdata = '0;
        lat   = (misal && !err) ? 2 : 1;
        if (err) return;
        val = '0;
        for (int k = 0; k < bytes; k++) begin
            int b;
            b = int'((addr + k) % (4 * DEPTH));
            if (we) mem_m[b] = wdata[8*k +: 8];
            else    val[8*k +: 8] = mem_m[b];
        end
        if (!we) begin
            if (bytes < 4 && !uns && val[8*bytes-1]) val = val | (32'hFFFF_FFFF << (8 * bytes));
            rdata = val;
        end
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic        e_err;
        logic [31:0] e_rdata;
        int          lat;
        int          guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", req_ready, 1);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        model(we, size, uns, addr, wdata, e_err, e_rdata, lat);
        e.err   = e_err;
        e.rdata = e_rdata;
        e.cyc   = cyc + lat;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: every response must match the oldest outstanding expectation, in the expected cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_err", rsp_err, e.err);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        for (int w = 0; w < DEPTH; w++) issue(1'b1, SZ_WORD, 1'b0, 32'(4 * w), $urandom);

        // Store/load, read-after-write, sub-word extension
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h7F);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0);
        issue(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0);
        issue(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0);

        // Range and illegal-size errors leave memory untouched
        issue(1'b1, SZ_WORD, 1'b0, 32'(4 * DEPTH), 32'h1234_5678);
        issue(1'b0, SZ_WORD, 1'b0, 32'(4 * DEPTH), 32'h0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        issue(1'b1, 2'd3, 1'b0, 32'h8, 32'hFFFF_FFFF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);

        // Misaligned word store: split or error depending on the build
        issue(1'b1, SZ_WORD, 1'b0, 32'h1, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_after_misaligned", req_ready, SPLIT_EN ? 1'b0 : 1'b1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
        issue(1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0);

        // Wrap from the last word back to word 0
        issue(1'b1, SZ_WORD, 1'b0, 32'(4 * DEPTH - 2), 32'hA1B2_C3D4);
        issue(1'b0, SZ_WORD, 1'b0, 32'(4 * DEPTH - 4), 32'h0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        issue(1'b0, SZ_WORD, 1'b0, 32'(4 * DEPTH - 2), 32'h0);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 7));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
        end
        drain();

`ifdef DMEM_MISALIGN_SPLIT_EN
        // Reset during SPLIT: first-half bytes stay written, no response appears
        @(negedge clk);
        req_we       = 1'b1;
        req_size     = SZ_WORD;
        req_unsigned = 1'b0;
        req_addr     = 32'h21;
        req_wdata    = 32'hCAFE_F00D;
        req_valid    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if ((32'h21 + k) / 4 == 32'h21 / 4) mem_m[32'h21 + k] = req_wdata[8*k +: 8];
        end
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        check("ready_in_reset", req_ready, 0);
        @(negedge clk);
        check("rsp_valid_in_reset", rsp_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", req_ready, 1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
